// File: rtl/ssd_count_driver_if.sv
// Control/status bundle between board inputs and the HEX0 count source.
// The master drives controls; the slave returns count and pulses.
interface ssd_count_driver_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             wrap;

  modport master (
    output en, up, load, load_val,
    input  count, tick, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tick, wrap
  );
endinterface

// File: rtl/ssd_count_driver.sv
// Prescaled, loadable up/down counter feeding the HEX0 decoder.
// tick/wrap pulses line up with the new count so HEX1 can cascade.
module ssd_count_driver #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 10,
  parameter int PRESCALE = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  ssd_count_driver_if.slave   bus
);
  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAXV =
    WIDTH'(MAX_VAL);

  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] count_q;
  logic             tick_q;
  logic             wrap_q;
  logic             step;
  logic [WIDTH-1:0] load_sat;

  assign step     = bus.en && (pre == PRE_LAST);
  assign load_sat =
    (bus.load_val > MAXV) ? MAXV : bus.load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre     <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      pre     <= '0;
      count_q <= load_sat;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (step) begin
      pre    <= '0;
      tick_q <= 1'b1;
      if (bus.up) begin
        if (count_q == MAXV) begin
          count_q <= '0;
          wrap_q  <= 1'b1;
        end else begin
          count_q <= count_q + WIDTH'(1);
          wrap_q  <= 1'b0;
        end
      end else begin
        if (count_q == '0) begin
          count_q <= MAXV;
          wrap_q  <= 1'b1;
        end else begin
          count_q <= count_q - WIDTH'(1);
          wrap_q  <= 1'b0;
        end
      end
    end else begin
      // en=0 leaves pre frozen; pulses drop either way
      if (bus.en) pre <= pre + PW'(1);
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: doc/ssd_count_driver.md
Name: ssd_count_driver

Overview:
- Sequential source for the HEX0 seven-segment decoder: a prescaled, loadable up/down counter that produces the 4-bit state the decoder consumes, constrained to 0..MAX_VAL (0000..1010 by default).
- Emits per-step and wrap pulses so a second digit (HEX1) can be cascaded.
- Sits between board switches/keys and the decoder in the top level.

Parameters:
- WIDTH, 4: counter width; must equal the decoder input width.
- MAX_VAL, 10: highest count value; legal range 1..2^WIDTH-1.
- PRESCALE, 50000000: number of enabled clk cycles per count step; must be >=1. 1 Hz at 50 MHz.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  prescaler/count enable; low freezes all counting state.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the step cycle only.
- load  input  1  synchronous load strobe; highest priority after rst.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  registered counter state; drives the decoder input.
- tick  output  1  one-cycle pulse in the cycle count first shows a stepped value.
- wrap  output  1  one-cycle pulse in the cycle count first shows a wrapped value (MAX_VAL->0 or 0->MAX_VAL).

Behaviour:
- Reset: rst=1 asynchronously forces count=0, tick=0, wrap=0 and prescaler=0, with no clock edge needed. First activity follows the first rising edge with rst=0.
- Prescaler: internal counter pre, range 0..PRESCALE-1, width ceil(log2(PRESCALE)) with a minimum of 1.
  - On each edge with en=1 and load=0: if pre==PRESCALE-1 then pre<=0 and a step occurs, else pre<=pre+1.
  - en=0: pre, count, tick and wrap hold; tick and wrap are forced 0.
- Step, up=1: count==MAX_VAL -> count<=0 and wrap<=1; otherwise count<=count+1 and wrap<=0.
- Step, up=0: count==0 -> count<=MAX_VAL and wrap<=1; otherwise count<=count-1 and wrap<=0.
- tick<=1 on every step edge; tick and wrap are 0 on all other edges. Both are registered and valid in the same cycle as the new count.
- Load: on an edge with load=1:
  - count<=load_val if load_val<=MAX_VAL, else count<=MAX_VAL (saturating, never out of range).
  - pre<=0; tick<=0; wrap<=0.
  - Load overrides a coincident step. Load acts regardless of en.
- Latency: with en held high from pre=0, the first step appears after PRESCALE edges; subsequent steps come every PRESCALE edges.
- PRESCALE=1: a step occurs on every enabled edge.
- count is never outside 0..MAX_VAL, whether via step, load or reset.
- A direction change mid-interval does not reset pre; only the value of up at the step edge matters.
- rst asserted mid-interval discards the partial prescale count.
- Arithmetic is on WIDTH bits. Comparisons against MAX_VAL and PRESCALE-1 are exact (no ≥ shortcuts that alter wrap points).

Test Plan (PRESCALE=4, MAX_VAL=10, WIDTH=4 unless stated):
- Reset: run to count=6, assert rst between edges -> count=0, tick=0, wrap=0 immediately. Release rst, en=1, up=1 -> count=1 with tick=1 exactly at the 4th edge.
- Up wrap: from reset, en=1, up=1 for 44 edges -> count steps 1..10. At edge 44 count=0, tick=1, wrap=1 for one cycle only; wrap=0 on all earlier steps.
- Down wrap: load 0, then up=0, en=1 -> 4 edges later count=10, wrap=1. 4 edges after that count=9, wrap=0.
- Load saturation and priority:
  - load_val=4'hC -> count=10.
  - load_val=7 asserted on the same edge as a due step -> count=7, tick=0, wrap=0; the next step comes 4 edges later (pre cleared).
- Enable freeze: 2 enabled edges, then en=0 for 10 edges -> count unchanged, tick=0. Re-enable -> step on the 2nd enabled edge.
- Degenerate prescale: PRESCALE=1, up=1, en=1 -> count 0,1,...,10,0 on consecutive edges; tick constantly 1; wrap=1 only on the 10->0 edge.
